fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter PC_W, default 18, PC and address width in bits.
REQ-002 SHALL have parameter INSTR_W, default 32, instruction word width.
REQ-003 SHALL have parameter DEPTH, default 4, queue entries; power of two, 2..16.
REQ-004 SHALL have parameter PC_STEP, default 4, PC increment per fetch.
REQ-005 SHALL have parameter RESET_PC, default 0, PC value after reset.
REQ-006 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst  in  1  reset, synchronous and active-low.
REQ-008 SHALL have port en  in  1  fetch enable; 0 blocks new requests only.
REQ-009 SHALL have port redirect_w  in  1  writeback-stage PC write.
REQ-010 SHALL have port redirect_w_pc  in  PC_W  writeback target PC.
REQ-011 SHALL have port branch_taken_e  in  1  execute-stage taken branch.
REQ-012 SHALL have port branch_pc_e  in  PC_W  branch target PC.
REQ-013 SHALL have port imem_req  out  1  fetch request; memory always accepts.
REQ-014 SHALL have port imem_addr  out  PC_W  request address.
REQ-015 SHALL have port imem_valid  in  1  in-order response strobe, latency >= 1 cycle.
REQ-016 SHALL have port imem_rdata  in  INSTR_W  response word.
REQ-017 SHALL have port deq_ready  in  1  decode accepts the head entry.
REQ-018 SHALL have port deq_valid  out  1  queue non-empty.
REQ-019 SHALL have port deq_instr  out  INSTR_W  head instruction.
REQ-020 SHALL have port deq_pc  out  PC_W  head instruction address.
REQ-021 SHALL have port deq_pc8  out  PC_W  deq_pc + 2*PC_STEP, mod 2^PC_W.

Function
REQ-022 SHALL keep PC register, count (stored entries 0..DEPTH), outst (in-flight requests 0..DEPTH), and disc (responses to drop).
REQ-023 SHALL assert imem_req combinationally iff rst=1, en=1, no redirect this cycle, and count+outst < DEPTH; imem_addr = PC at all times.
REQ-024 SHALL, on an issued request, set PC <= PC+PC_STEP, mod 2^PC_W; wrap from max to 0 is legal.
REQ-025 SHALL track each request's address in a DEPTH-entry in-order tag FIFO; a kept response enqueues {imem_rdata, tag address} at tail.
REQ-026 SHALL drop a response (no enqueue) while disc > 0, decrementing disc, or while outst = 0 (stray response).
REQ-027 SHALL decrement outst on every response with outst > 0, and increment it on every issue; both in one cycle leave it unchanged.
REQ-028 SHALL pop the head when deq_valid=1 and deq_ready=1; enqueue and pop in one cycle leave count unchanged; a response never finds the queue full (REQ-023 invariant).
REQ-029 SHALL present deq_instr, deq_pc, deq_pc8 from the head combinationally; values undefined when deq_valid=0.
REQ-030 SHALL give redirect_w priority over branch_taken_e when both are 1.
REQ-031 SHALL, on a redirect, set PC <= selected target, clear the queue (count <= 0, pop ignored), set disc <= outst - (imem_valid ? 1 : 0) + disc adjustment so that every request outstanding at that edge, including one returning that cycle, is dropped, and issue nothing that cycle.
REQ-032 SHALL apply redirects regardless of en.
REQ-033 SHALL, with en=0, keep PC and outst-issue frozen while still accepting responses and pops.
REQ-034 SHALL have first-fetch latency after redirect of 1 cycle to imem_req plus memory latency to deq_valid.

Reset
REQ-035 SHALL, while rst=0 at a clock edge, set PC <= RESET_PC, count, outst, disc <= 0; imem_req=0 and deq_valid=0 during reset.
REQ-036 SHALL, after rst is released mid-operation, ignore responses to pre-reset requests under REQ-026, with outst = 0.

Verification
REQ-037 Streaming: DEPTH=4, latency 1, deq_ready=1 -> deq_pc 0,4,8,12,... one per cycle, deq_pc8 = deq_pc+8.
REQ-038 Backpressure: deq_ready=0, latency 2 -> exactly 4 requests issued, then imem_req=0; deq_ready=1 for one cycle -> one pop, one new request.
REQ-039 Branch: latency 3, 3 in flight, branch_taken_e=1, branch_pc_e=0x100 -> queue empties, next 3 responses dropped, first deq_pc = 0x100.
REQ-040 Simultaneous redirect: redirect_w_pc=0x200 with branch_taken_e and branch_pc_e=0x300 -> fetch resumes at 0x200.
REQ-041 Wrap: PC_W=18, RESET_PC=0x3FFFC -> deq_pc 0x3FFFC then 0x00000, deq_pc8 of first = 0x00004.
REQ-042 Reset mid-flight: rst=0 for 1 cycle with 2 outstanding, then stray imem_valid -> deq_valid stays 0, PC = RESET_PC.

Source files
------------

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Brief    : Instruction fetch PC generator with in-order tag FIFO and a
//            decoded-ready instruction queue; redirects flush and discard.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter int              PC_W     = 18,
  parameter int              INSTR_W  = 32,
  parameter int              DEPTH    = 4,
  parameter int              PC_STEP  = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               redirect_w,
  input  logic [PC_W-1:0]    redirect_w_pc,
  input  logic               branch_taken_e,
  input  logic [PC_W-1:0]    branch_pc_e,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               deq_ready,
  output logic               deq_valid,
  output logic [INSTR_W-1:0] deq_instr,
  output logic [PC_W-1:0]    deq_pc,
  output logic [PC_W-1:0]    deq_pc8
);

  localparam int              PTR_W       = $clog2(DEPTH);
  localparam int              CNT_W       = $clog2(DEPTH + 1);
  localparam logic [PC_W-1:0] C_PC_STEP   = PC_W'(PC_STEP);
  localparam logic [PC_W-1:0] C_PC_STEP2  = PC_W'(2 * PC_STEP);

  logic [PC_W-1:0]    r_pc;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_outst;
  logic [CNT_W-1:0]   r_disc;
  logic [PTR_W-1:0]   r_tag_wr;
  logic [PTR_W-1:0]   r_tag_rd;
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [PC_W-1:0]    r_tag_mem   [DEPTH];
  logic [PC_W-1:0]    r_pc_mem    [DEPTH];
  logic [INSTR_W-1:0] r_instr_mem [DEPTH];

  logic               w_redirect;
  logic [PC_W-1:0]    w_target;
  logic [CNT_W:0]     w_occupancy;
  logic               w_resp;
  logic               w_keep;
  logic               w_pop;

  assign w_redirect  = redirect_w | branch_taken_e;
  assign w_target    = redirect_w ? redirect_w_pc : branch_pc_e;
  // Stored plus in-flight never exceeds DEPTH, so a kept response always has room.
  assign w_occupancy = {1'b0, r_count} + {1'b0, r_outst};
  assign imem_req    = rst & en & ~w_redirect & (w_occupancy < (CNT_W + 1)'(DEPTH));
  assign imem_addr   = r_pc;

  // A response with nothing outstanding is a stray from before reset.
  assign w_resp      = imem_valid & (r_outst != '0);
  assign w_keep      = w_resp & (r_disc == '0) & ~w_redirect;

  assign deq_valid   = rst & (r_count != '0);
  assign w_pop       = deq_valid & deq_ready & ~w_redirect;
  assign deq_instr   = r_instr_mem[r_head];
  assign deq_pc      = r_pc_mem[r_head];
  assign deq_pc8     = deq_pc + C_PC_STEP2;

  always_ff @(posedge clk) begin
    if (imem_req) begin
      r_tag_mem[r_tag_wr] <= r_pc;
    end
    if (w_keep) begin
      r_instr_mem[r_tail] <= imem_rdata;
      r_pc_mem[r_tail]    <= r_tag_mem[r_tag_rd];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc     <= RESET_PC;
      r_count  <= '0;
      r_outst  <= '0;
      r_disc   <= '0;
      r_tag_wr <= '0;
      r_tag_rd <= '0;
      r_head   <= '0;
      r_tail   <= '0;
    end else begin
      if (w_redirect) begin
        r_pc <= w_target;
      end else if (imem_req) begin
        r_pc <= r_pc + C_PC_STEP;
      end

      case ({imem_req, w_resp})
        2'b10:   r_outst <= r_outst + CNT_W'(1);
        2'b01:   r_outst <= r_outst - CNT_W'(1);
        default: r_outst <= r_outst;
      endcase

      // Every request still in flight after this edge belongs to the old path.
      if (w_redirect) begin
        r_disc <= r_outst - CNT_W'(w_resp);
      end else if (w_resp && (r_disc != '0)) begin
        r_disc <= r_disc - CNT_W'(1);
      end

      if (imem_req) begin
        r_tag_wr <= r_tag_wr + PTR_W'(1);
      end
      if (w_resp) begin
        r_tag_rd <= r_tag_rd + PTR_W'(1);
      end

      if (w_redirect) begin
        r_count <= '0;
        r_head  <= '0;
        r_tail  <= '0;
      end else begin
        if (w_keep) begin
          r_tail <= r_tail + PTR_W'(1);
        end
        if (w_pop) begin
          r_head <= r_head + PTR_W'(1);
        end
        case ({w_keep, w_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
